// File: rtl/serial_subtractor_pkg.sv
// Shared state encodings and default width for the bit-serial subtractor.
// Optional signed overflow output is enabled with SERIAL_SUBTRACTOR_OVF_EN.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit full-subtractor cell: diff = a - b - bin, bout = borrow out.
// Purely combinational, zero latency, no flow control.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first serial a - b; done pulses WIDTH+1 cycles after start is presented.
// start is only accepted in IDLE; SERIAL_SUBTRACTOR_OVF_EN adds a signed ovf output.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] res_full;
  logic             last_bit;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  full_subtractor u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .diff (d),
    .bout (br_nxt)
  );

  // Result register holds the upper WIDTH-1 bits; the incoming bit completes it.
  assign res_full = {d, res};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= 1'b0;
            cnt <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_full[WIDTH-1:1];
          br  <= br_nxt;
          cnt <= cnt + CW'(1);
          // Outputs change only once, so partial results are never visible.
          if (last_bit) begin
            diff   <= res_full;
            borrow <= br_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf    <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8: vector table plus corner sequences.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and check latency, hold and final result.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
    logic [W-1:0] held;
    int n;
    held  = diff;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~av;
    b     = av ^ bv;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    n = 1;
    while (!done && n < 40) begin
      chk("diff_hold_busy", {24'd0, diff}, {24'd0, held});
      tick();
      n++;
    end
    last_done_cyc = cyc;
    chk("done_latency", n, W + 1);
    chk("diff", {24'd0, diff}, {24'd0, ed});
    chk("borrow", {31'd0, borrow}, {31'd0, eb});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) chk("ovf_unused", 32'd0, 32'd1);
`endif
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("diff_hold_after", {24'd0, diff}, {24'd0, ed});
    chk("borrow_hold_after", {31'd0, borrow}, {31'd0, eb});
  endtask

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_borrow", {31'd0, borrow}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow, vecs[i].exp_ovf);

    // start during RUN must be ignored
    begin
      int n;
      a = 8'h10; b = 8'h01; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      a = 8'hAA; b = 8'h55; start = 1'b1;
      tick();
      start = 1'b0;
      n = 5;
      while (!done && n < 40) begin tick(); n++; end
      chk("ign_latency", n, W + 1);
      chk("ign_diff", {24'd0, diff}, 32'h0F);
      chk("ign_borrow", {31'd0, borrow}, 32'd0);
      tick();
      tick();
      chk("ign_idle_busy", {31'd0, busy}, 32'd0);
      chk("ign_idle_done", {31'd0, done}, 32'd0);
    end

    // reset mid-RUN discards the operation
    a = 8'h20; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_diff", {24'd0, diff}, 32'd0);
    chk("mid_rst_borrow", {31'd0, borrow}, 32'd0);
    tick();
    chk("mid_rst_stays_idle", {31'd0, busy}, 32'd0);
    do_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

    // back-to-back: second start in the first IDLE cycle after done
    begin
      int first_done;
      do_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0);
      first_done = last_done_cyc;
      do_op(8'h11, 8'h33, 8'hDE, 1'b1, 1'b0);
      chk("b2b_spacing", last_done_cyc - first_done, W + 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
